cmd_sequencer: RTL

Sequences a stored list of 16-bit move commands into the UART command transmitter (`RemoteComm`-style snd_cmd/cmd_snt/resp_rdy/resp handshake) that drives `KnightsTour`. Each command is issued, its 8-bit response is checked against positive-ack 0xA5, and the command is retried on a NAK or timeout. The block sits between a host/tour-solver that loads the move list and the command link. It gives benches and the top level one scheduler for the shared link, in place of hand-timed `send_cmd` pulses.

---
 rtl/cmd_seq_pkg.sv | 23 ++
 rtl/cmd_seq_if.sv | 25 ++
 rtl/cmd_seq_mem.sv | 38 +++
 rtl/cmd_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command sequencer.
package cmd_seq_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        NEXT,
        DONE
    } state_t;

    // Response byte that acknowledges a command.
    localparam logic [7:0] POS_ACK = 8'hA5;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmd_seq_if.sv
// Command link handshake between the sequencer (master) and the UART
// command transmitter (slave).
interface cmd_seq_if;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output cmd,
        output snd_cmd,
        input  cmd_snt,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  cmd,
        input  snd_cmd,
        output cmd_snt,
        output resp_rdy,
        output resp
    );
endinterface

// File: rtl/cmd_seq_mem.sv
// Command list storage: DEPTH x 16 register file, synchronous write and
// registered read. The read register doubles as the command driven onto the
// link, so it is reset while the array itself is not.
module cmd_seq_mem
    import cmd_seq_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int IW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value between reads so the command stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Issues a stored list of move commands over the command link one at a time,
// checks each response against the positive ack, and retries on NAK/timeout.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter  int DEPTH       = 32,
    parameter  int TIMEOUT_CYC = 2_000_000,
    parameter  int MAX_RETRY   = 2,
    localparam int IW          = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [IW:0]   num_cmds,
    input  logic          start,
    input  logic          abort,
    cmd_seq_if.master     link,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] err_cmd_idx,
    output logic [IW-1:0] cmd_idx
);

    localparam int NW = IW + 1;
    localparam int TW = idx_width(TIMEOUT_CYC + 1);
    localparam int RW = idx_width(MAX_RETRY + 1);

    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    state_t        state;
    state_t        state_nxt;
    logic [NW-1:0] n_run;
    logic [NW-1:0] n_clamp;
    logic [RW-1:0] retry;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          ack_rx;
    logic          last_cmd;
    logic          retry_ok;
    logic          load_run;
    logic          adv_idx;
    logic          clr_retry;
    logic          do_retry;
    logic          do_fail;
    logic          mem_we;
    logic          mem_re;
    logic [15:0]   mem_rdata;

    assign n_clamp  = (num_cmds > DEPTH_N) ? DEPTH_N : num_cmds;
    assign tmo_hit  = (tmo_cnt == TMO_MAX);
    assign ack_rx   = link.resp_rdy && (link.resp == POS_ACK);
    assign last_cmd = ({1'b0, cmd_idx} == (n_run - 1'b1));
    assign retry_ok = (int'(retry) < MAX_RETRY);

    // The list is writable only while no run is using it.
    assign mem_we = wr_en && (state == IDLE);
    assign mem_re = (state == FETCH) && !abort;

    cmd_seq_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (mem_re),
        .raddr (cmd_idx),
        .rdata (mem_rdata)
    );

    // Pulses are gated by abort so an aborted SEND/DONE cycle issues nothing.
    assign link.cmd     = mem_rdata;
    assign link.snd_cmd = (state == SEND) && !abort;
    assign done         = (state == DONE) && !abort;
    assign busy         = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle control strobes; abort overrides everything.
    always_comb begin
        state_nxt = state;
        load_run  = 1'b0;
        adv_idx   = 1'b0;
        clr_retry = 1'b0;
        do_retry  = 1'b0;
        do_fail   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        load_run  = 1'b1;
                        state_nxt = (n_clamp == '0) ? DONE : FETCH;
                    end
                end
                FETCH: state_nxt = SEND;
                SEND:  state_nxt = WAIT_SNT;
                WAIT_SNT: begin
                    if (link.cmd_snt) begin
                        state_nxt = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    // A response arriving on the expiry cycle takes precedence.
                    if (ack_rx) begin
                        state_nxt = NEXT;
                    end else if (link.resp_rdy || tmo_hit) begin
                        if (retry_ok) begin
                            do_retry  = 1'b1;
                            state_nxt = SEND;
                        end else begin
                            do_fail   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                NEXT: begin
                    clr_retry = 1'b1;
                    if (last_cmd) begin
                        state_nxt = DONE;
                    end else begin
                        adv_idx   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Run bookkeeping: command count, current index, retry count, error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_run       <= '0;
            cmd_idx     <= '0;
            retry       <= '0;
            err         <= 1'b0;
            err_cmd_idx <= '0;
        end else begin
            if (load_run) begin
                n_run   <= n_clamp;
                cmd_idx <= '0;
                retry   <= '0;
                err     <= 1'b0;
            end
            if (adv_idx) begin
                cmd_idx <= cmd_idx + 1'b1;
            end
            if (clr_retry) begin
                retry <= '0;
            end
            if (do_retry) begin
                retry <= retry + 1'b1;
            end
            if (do_fail) begin
                err         <= 1'b1;
                err_cmd_idx <= cmd_idx;
            end
        end
    end

    // Response timeout: restarts when the link reports the command sent,
    // then counts WAIT_RESP cycles and saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_SNT) && link.cmd_snt) begin
            tmo_cnt <= '0;
        end else if ((state == WAIT_RESP) && (tmo_cnt != TMO_MAX)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule
